// File: rtl/fdivsqrt_ctrl_if.sv
// Handshake bundle between the Execute stage and the divide/sqrt control FSM.
// The slave modport is the controller side; the master modport is the pipeline side.
interface fdivsqrt_ctrl_if #(
    parameter int FMTBITS = 2
);
    logic               FDivStartE;
    logic               SqrtE;
    logic [FMTBITS-1:0] FmtE;
    logic               XsE;
    logic               XZeroE;
    logic               YZeroE;
    logic               XInfE;
    logic               YInfE;
    logic               XNaNE;
    logic               YNaNE;
    logic               WZeroE;
    logic               FlushE;
    logic               StallM;
    logic               IterEnE;
    logic               IFDivStartE;
    logic               FDivBusyE;
    logic               FDivDoneE;
    logic               SpecialCaseM;

    modport master (
        output FDivStartE, SqrtE, FmtE, XsE, XZeroE, YZeroE, XInfE, YInfE,
               XNaNE, YNaNE, WZeroE, FlushE, StallM,
        input  IterEnE, IFDivStartE, FDivBusyE, FDivDoneE, SpecialCaseM
    );

    modport slave (
        input  FDivStartE, SqrtE, FmtE, XsE, XZeroE, YZeroE, XInfE, YInfE,
               XNaNE, YNaNE, WZeroE, FlushE, StallM,
        output IterEnE, IFDivStartE, FDivBusyE, FDivDoneE, SpecialCaseM
    );
endinterface

// File: rtl/fdivsqrt_ctrl.sv
// Control FSM for the iterative divide/sqrt recurrence: special-case bypass,
// per-format iteration count, early exit on zero residual, and stall/flush handling.
module fdivsqrt_ctrl #(
    parameter int NF        = 52,
    parameter int FMTBITS   = 2,
    parameter int LOGR      = 1,
    parameter int DIVCOPIES = 4,
    parameter int CNTW      = 6
) (
    input  logic            clk,
    input  logic            reset,
    fdivsqrt_ctrl_if.slave  bus
);
    localparam int BITS_PER_CYCLE = LOGR * DIVCOPIES;

    // ceil((nf + 3) / bits_per_cycle): fraction plus guard/integer bits
    function automatic logic [CNTW-1:0] iter_cycles(input int nf);
        return CNTW'((nf + 3 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE);
    endfunction

    localparam logic [CNTW-1:0] CYC_SINGLE = iter_cycles(23);
    localparam logic [CNTW-1:0] CYC_DOUBLE = iter_cycles(NF);
    localparam logic [CNTW-1:0] CYC_HALF   = iter_cycles(10);
    localparam logic [CNTW-1:0] CYC_QUAD   = iter_cycles(112);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cycles;
    logic            special;
    logic            special_q;
    logic            start_ok;
    logic            iter_en;

    always_comb begin
        cycles = CYC_DOUBLE;
        case (bus.FmtE)
            FMTBITS'(0): cycles = CYC_SINGLE;
            FMTBITS'(1): cycles = CYC_DOUBLE;
            FMTBITS'(2): cycles = CYC_HALF;
            default:     cycles = CYC_QUAD;
        endcase
    end

    // Negative non-zero radicand is a NaN result, so it bypasses the recurrence too
    always_comb begin
        if (bus.SqrtE)
            special = bus.XNaNE | bus.XInfE | bus.XZeroE | (bus.XsE & ~bus.XZeroE);
        else
            special = bus.XNaNE | bus.YNaNE | bus.XInfE | bus.YInfE |
                      bus.XZeroE | bus.YZeroE;
    end

    assign start_ok = (state == S_IDLE) & bus.FDivStartE & ~bus.FlushE;
    assign iter_en  = (state == S_BUSY) & ~bus.FlushE;

    always_comb begin
        state_n = state;
        if (bus.FlushE) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.FDivStartE) state_n = special ? S_DONE : S_BUSY;
                S_BUSY:  if ((cnt == '0) || bus.WZeroE) state_n = S_DONE;
                S_DONE:  if (!bus.StallM) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            special_q <= 1'b0;
        end else begin
            state <= state_n;
            if (start_ok) begin
                special_q <= special;
                if (!special)
                    cnt <= cycles - CNTW'(1);
            end else if (iter_en && (cnt != '0)) begin
                cnt <= cnt - CNTW'(1);
            end
        end
    end

    // Combinational outputs are forced low while reset is held
    assign bus.IterEnE      = ~reset & iter_en;
    assign bus.IFDivStartE  = ~reset & start_ok & ~special;
    assign bus.FDivBusyE    = ~reset & ((state == S_BUSY) | start_ok);
    assign bus.FDivDoneE    = ~reset & (state == S_DONE);
    assign bus.SpecialCaseM = special_q;
endmodule

// File: tb/tb_fdivsqrt_ctrl.sv
// Randomized scoreboard bench for fdivsqrt_ctrl: stimulus pushes expected
// completions, a negedge monitor pops and checks them when FDivDoneE rises.
module tb_fdivsqrt_ctrl;
    logic clk = 1'b0;
    logic rst;

    fdivsqrt_ctrl_if #(.FMTBITS(2)) bus();

    fdivsqrt_ctrl #(.NF(52), .FMTBITS(2), .LOGR(1), .DIVCOPIES(4), .CNTW(6)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int RATE = 4;

    typedef struct {
        int start;
        int lat;
        int iters;
        int ifd;
        bit spec;
        int hold;
    } exp_t;

    typedef struct {
        bit         sqrt;
        logic [1:0] fmt;
        bit         xs, xz, yz, xi, yi, xn, yn;
        int         wz_at;
        int         stall;
        int         flush_at;
        int         rst_at;
        bit         sid;
        int         gap;
    } op_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic from the format and operand rules
    function automatic int model_nf(input logic [1:0] f);
        case (f)
            2'b00:   return 23;
            2'b01:   return 52;
            2'b10:   return 10;
            default: return 112;
        endcase
    endfunction

    function automatic int model_cycles(input logic [1:0] f);
        return (model_nf(f) + 3 + RATE - 1) / RATE;
    endfunction

    function automatic bit model_special(input op_t o);
        if (o.sqrt) return o.xn || o.xi || o.xz || (o.xs && !o.xz);
        return o.xn || o.yn || o.xi || o.yi || o.xz || o.yz;
    endfunction

    function automatic op_t mk(input bit sq, input logic [1:0] f);
        op_t o;
        o = '{default: 0};
        o.sqrt = sq;
        o.fmt = f;
        o.flush_at = -1;
        o.rst_at = -1;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        bus.SqrtE  = 1'($urandom_range(0, 1));
        bus.FmtE   = 2'($urandom_range(0, 3));
        bus.XsE    = 1'($urandom_range(0, 1));
        bus.XZeroE = 1'($urandom_range(0, 1));
        bus.YZeroE = 1'($urandom_range(0, 1));
        bus.XInfE  = 1'($urandom_range(0, 1));
        bus.YInfE  = 1'($urandom_range(0, 1));
        bus.XNaNE  = 1'($urandom_range(0, 1));
        bus.YNaNE  = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_op(input op_t o);
        bus.SqrtE  = o.sqrt;
        bus.FmtE   = o.fmt;
        bus.XsE    = o.xs;
        bus.XZeroE = o.xz;
        bus.YZeroE = o.yz;
        bus.XInfE  = o.xi;
        bus.YInfE  = o.yi;
        bus.XNaNE  = o.xn;
        bus.YNaNE  = o.yn;
    endtask

    task automatic run_op(input op_t o);
        bit   spec;
        int   n, lat, iters, abort_at;
        exp_t e;
        spec = model_special(o);
        n = model_cycles(o.fmt);
        abort_at = (o.flush_at >= 0) ? o.flush_at : o.rst_at;
        if (spec) begin
            lat = 1; iters = 0;
        end else if (o.wz_at > 0) begin
            lat = o.wz_at + 1; iters = o.wz_at;
        end else begin
            lat = n + 1; iters = n;
        end
        if (abort_at < 0) begin
            e.start = cyc; e.lat = lat; e.iters = iters;
            e.ifd = spec ? 0 : 1; e.spec = spec; e.hold = o.stall + 1;
            sb.push_back(e);
        end
        for (int t = 0; ; t++) begin
            if (t == 0) drive_op(o);
            else drive_rand();
            bus.FDivStartE = (t == 0) || (o.sid && t == lat) ||
                             (t > 0 && $urandom_range(0, 3) == 0);
            bus.WZeroE = !spec && o.wz_at > 0 && t == o.wz_at;
            bus.StallM = (t >= lat) ? (t < lat + o.stall) : 1'($urandom_range(0, 1));
            bus.FlushE = (o.flush_at == t);
            rst        = (o.rst_at == t);
            tick();
            if (abort_at >= 0 && t == abort_at) break;
            if (abort_at < 0 && t == lat + o.stall) break;
        end
        if (abort_at >= 0) begin
            bus.FDivStartE = 1'b0; bus.FlushE = 1'b0; bus.StallM = 1'b0; bus.WZeroE = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            check("abort_iteren", int'(bus.IterEnE), 0);
            check("abort_ifdstart", int'(bus.IFDivStartE), 0);
            check("abort_busy", int'(bus.FDivBusyE), 0);
            check("abort_done", int'(bus.FDivDoneE), 0);
            if (o.rst_at >= 0 || abort_at > 0)
                check("abort_special", int'(bus.SpecialCaseM), 0);
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < o.gap; g++) begin
            drive_rand();
            bus.FDivStartE = 1'b0;
            bus.WZeroE = 1'($urandom_range(0, 1));
            bus.StallM = 1'($urandom_range(0, 1));
            bus.FlushE = ($urandom_range(0, 7) == 0);
            tick();
        end
    endtask

    // Monitor: checks each completion against the oldest outstanding expectation
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   done_prev = 1'b0;
    int   hold_cnt = 0;
    int   iter_cnt = 0;
    int   ifd_cnt = 0;

    always @(negedge clk) begin
        if (bus.FDivDoneE === 1'b1) begin
            if (!done_prev) begin
                check("pending_on_done", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    check("done_latency", cyc - cur.start, cur.lat);
                    check("iter_count", iter_cnt, cur.iters);
                    check("start_pulses", ifd_cnt, cur.ifd);
                end else begin
                    have_cur = 1'b0;
                end
                hold_cnt = 1;
            end else begin
                hold_cnt++;
            end
            check("busy_in_done", int'(bus.FDivBusyE), 0);
            if (have_cur) check("special_case", int'(bus.SpecialCaseM), int'(cur.spec));
        end else if (done_prev && have_cur) begin
            check("done_hold", hold_cnt, cur.hold);
            have_cur = 1'b0;
        end
        done_prev = (bus.FDivDoneE === 1'b1);
        if (bus.FDivBusyE !== 1'b1) begin
            iter_cnt = 0;
            ifd_cnt = 0;
        end
        if (bus.IterEnE === 1'b1) iter_cnt++;
        if (bus.IFDivStartE === 1'b1) ifd_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        bit  spec;
        int  n;
        rst = 1'b1;
        bus.FDivStartE = 1'b0; bus.SqrtE = 1'b0; bus.FmtE = 2'b00; bus.XsE = 1'b0;
        bus.XZeroE = 1'b0; bus.YZeroE = 1'b0; bus.XInfE = 1'b0; bus.YInfE = 1'b0;
        bus.XNaNE = 1'b0; bus.YNaNE = 1'b0; bus.WZeroE = 1'b0; bus.FlushE = 1'b0;
        bus.StallM = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("reset_iteren", int'(bus.IterEnE), 0);
        check("reset_ifdstart", int'(bus.IFDivStartE), 0);
        check("reset_busy", int'(bus.FDivBusyE), 0);
        check("reset_done", int'(bus.FDivDoneE), 0);
        check("reset_special", int'(bus.SpecialCaseM), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        o = mk(0, 2'b01); o.gap = 1; run_op(o);
        o = mk(1, 2'b00); o.xs = 1; o.gap = 1; run_op(o);
        o = mk(0, 2'b10); o.wz_at = 2; o.gap = 1; run_op(o);
        o = mk(0, 2'b11); o.flush_at = 10; o.gap = 1; run_op(o);
        o = mk(0, 2'b11); o.gap = 1; run_op(o);
        o = mk(0, 2'b01); o.stall = 3; o.sid = 1; o.gap = 1; run_op(o);
        o = mk(0, 2'b01); o.rst_at = 5; run_op(o);
        o = mk(0, 2'b01); o.yz = 1; o.gap = 1; run_op(o);

        for (int k = 0; k < 80; k++) begin
            o = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            o.xs = ($urandom_range(0, 3) == 0);
            o.xz = ($urandom_range(0, 9) == 0);
            o.yz = ($urandom_range(0, 9) == 0);
            o.xi = ($urandom_range(0, 15) == 0);
            o.yi = ($urandom_range(0, 15) == 0);
            o.xn = ($urandom_range(0, 15) == 0);
            o.yn = ($urandom_range(0, 15) == 0);
            spec = model_special(o);
            n = model_cycles(o.fmt);
            case ($urandom_range(0, 7))
                0: o.flush_at = spec ? 0 : int'($urandom_range(0, n));
                1: o.rst_at   = spec ? 0 : int'($urandom_range(0, n));
                2, 3: if (!spec) o.wz_at = int'($urandom_range(1, n));
                default: ;
            endcase
            o.stall = int'($urandom_range(0, 3));
            o.sid = 1'($urandom_range(0, 1));
            o.gap = int'($urandom_range(0, 2));
            run_op(o);
        end

        bus.FDivStartE = 1'b0; bus.FlushE = 1'b0; bus.StallM = 1'b0;
        repeat (3) tick();
        check("scoreboard_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
